// File: rtl/ula_pkg.sv
// Shared types and opcode helpers for the sequential ALU (ula_seq / ula_comb).
package ula_pkg;

  typedef enum logic [4:0] {
    OP_ADD       = 5'b00000,
    OP_ADD1      = 5'b00001,
    OP_ADC       = 5'b00010,
    OP_INC       = 5'b00011,
    OP_SUBM1     = 5'b00100,
    OP_SUB       = 5'b00101,
    OP_DEC       = 5'b00110,
    OP_SBC       = 5'b00111,
    OP_LSL       = 5'b01000,
    OP_ASR       = 5'b01001,
    OP_ZERO      = 5'b10000,
    OP_AND       = 5'b10001,
    OP_NA_AND_B  = 5'b10010,
    OP_B         = 5'b10011,
    OP_A_AND_NB  = 5'b10100,
    OP_A         = 5'b10101,
    OP_XOR       = 5'b10110,
    OP_OR        = 5'b10111,
    OP_NOR       = 5'b11000,
    OP_XNOR      = 5'b11001,
    OP_NA        = 5'b11010,
    OP_NA_OR_B   = 5'b11011,
    OP_NB        = 5'b11100,
    OP_A_OR_NB   = 5'b11101,
    OP_NAND      = 5'b11110,
    OP_ONES      = 5'b11111
  } op_e;

  typedef enum logic {IDLE, SHIFT} state_e;

  typedef struct packed {
    logic o;
    logic c;
    logic s;
    logic z;
  } flags_t;

  function automatic logic is_shift(input logic [4:0] op);
    return (op == OP_LSL) || (op == OP_ASR);
  endfunction

  function automatic logic is_arith(input logic [4:0] op);
    return op[4:3] == 2'b00;
  endfunction

endpackage

// File: rtl/ula_comb.sv
// Combinational result and flags for every single-cycle opcode of the ALU.
// ULA_SAT_EN: saturate overflowing arithmetic results instead of wrapping.
module ula_comb
  import ula_pkg::*;
#(
  parameter int W = 16
) (
  input  logic [4:0]   op_i,
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         carry_i,
  output logic [W-1:0] resu_o,
  output flags_t       flags_o,
  output logic         illegal_o
);

  logic [W-1:0] y;
  logic [W-1:0] res;
  logic [W:0]   sum;
  logic         ci;
  logic         ill;
  flags_t       fl;

  always_comb begin
    y   = '0;
    ci  = 1'b0;
    ill = 1'b0;
    res = '0;
    sum = '0;
    fl  = '0;
    case (op_i)
      OP_ADD:      y = b_i;
      OP_ADD1:     begin y = b_i;  ci = 1'b1;    end
      OP_ADC:      begin y = b_i;  ci = carry_i; end
      OP_INC:      begin y = '0;   ci = 1'b1;    end
      OP_SUBM1:    y = ~b_i;
      OP_SUB:      begin y = ~b_i; ci = 1'b1;    end
      OP_DEC:      y = '1;
      OP_SBC:      begin y = ~b_i; ci = carry_i; end
      // Zero-distance shifts complete here; longer ones iterate in ula_seq.
      OP_LSL,
      OP_ASR:      res = a_i;
      OP_ZERO:     res = '0;
      OP_AND:      res = a_i & b_i;
      OP_NA_AND_B: res = ~a_i & b_i;
      OP_B:        res = b_i;
      OP_A_AND_NB: res = a_i & ~b_i;
      OP_A:        res = a_i;
      OP_XOR:      res = a_i ^ b_i;
      OP_OR:       res = a_i | b_i;
      OP_NOR:      res = ~(a_i | b_i);
      OP_XNOR:     res = ~(a_i ^ b_i);
      OP_NA:       res = ~a_i;
      OP_NA_OR_B:  res = ~a_i | b_i;
      OP_NB:       res = ~b_i;
      OP_A_OR_NB:  res = a_i | ~b_i;
      OP_NAND:     res = ~(a_i & b_i);
      OP_ONES:     res = '1;
      default:     ill = 1'b1;
    endcase

    if (is_arith(op_i)) begin
      sum  = {1'b0, a_i} + {1'b0, y} + {{W{1'b0}}, ci};
      fl.c = sum[W];
      fl.o = (a_i[W-1] == y[W-1]) && (sum[W-1] != a_i[W-1]);
`ifdef ULA_SAT_EN
      if (fl.o)
        res = a_i[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
      else
        res = sum[W-1:0];
`else
      res = sum[W-1:0];
`endif
    end

    if (!ill) begin
      fl.s = res[W-1];
      fl.z = (res == '0);
    end
  end

  assign resu_o    = res;
  assign flags_o   = fl;
  assign illegal_o = ill;

endmodule

// File: rtl/ula_seq.sv
// Sequential ALU: valid/ready handshake, persistent O/C/S/Z flags, one op in flight,
// iterative one-bit-per-cycle shifter. ULA_SAT_EN enables saturating arithmetic.
module ula_seq
  import ula_pkg::*;
#(
  parameter int W  = 16,
  parameter int SW = $clog2(W)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [4:0]   op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] resu,
  output logic         flag_o,
  output logic         flag_c,
  output logic         flag_s,
  output logic         flag_z,
  output logic         illegal
);

  state_e        state_q, state_d;
  logic [W-1:0]  resu_q, resu_d;
  flags_t        flags_q, flags_d;
  logic          illegal_q, illegal_d;
  logic          out_valid_q, out_valid_d;
  logic [W-1:0]  sh_val_q, sh_val_d;
  logic [SW-1:0] sh_cnt_q, sh_cnt_d;
  logic          sh_asr_q, sh_asr_d;

  logic [W-1:0]  c_resu;
  flags_t        c_flags;
  logic          c_ill;
  logic [SW-1:0] shamt;
  logic          accept;
  logic [W-1:0]  sh_next;
  logic          sh_out;

  ula_comb #(.W(W)) u_comb (
    .op_i      (op),
    .a_i       (a),
    .b_i       (b),
    .carry_i   (flags_q.c),
    .resu_o    (c_resu),
    .flags_o   (c_flags),
    .illegal_o (c_ill)
  );

  assign shamt    = b[SW-1:0];
  assign in_ready = !rst && (state_q == IDLE) && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d     = state_q;
    resu_d      = resu_q;
    flags_d     = flags_q;
    illegal_d   = illegal_q;
    out_valid_d = out_valid_q && !out_ready;
    sh_val_d    = sh_val_q;
    sh_cnt_d    = sh_cnt_q;
    sh_asr_d    = sh_asr_q;
    sh_next     = sh_asr_q ? {sh_val_q[W-1], sh_val_q[W-1:1]} : {sh_val_q[W-2:0], 1'b0};
    sh_out      = sh_asr_q ? sh_val_q[0] : sh_val_q[W-1];

    case (state_q)
      IDLE: begin
        if (accept) begin
          if (is_shift(op) && (shamt != '0)) begin
            sh_val_d = a;
            sh_cnt_d = shamt;
            sh_asr_d = (op == OP_ASR);
            state_d  = SHIFT;
          end else begin
            resu_d      = c_resu;
            flags_d     = c_flags;
            illegal_d   = c_ill;
            out_valid_d = 1'b1;
          end
        end
      end
      SHIFT: begin
        sh_val_d = sh_next;
        sh_cnt_d = sh_cnt_q - SW'(1);
        // The final shift writes the result directly, giving latency 1+shamt.
        if (sh_cnt_q == SW'(1)) begin
          resu_d      = sh_next;
          flags_d     = '{o: 1'b0, c: sh_out, s: sh_next[W-1], z: (sh_next == '0)};
          illegal_d   = 1'b0;
          out_valid_d = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      resu_q      <= '0;
      flags_q     <= '0;
      illegal_q   <= 1'b0;
      out_valid_q <= 1'b0;
      sh_val_q    <= '0;
      sh_cnt_q    <= '0;
      sh_asr_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      resu_q      <= resu_d;
      flags_q     <= flags_d;
      illegal_q   <= illegal_d;
      out_valid_q <= out_valid_d;
      sh_val_q    <= sh_val_d;
      sh_cnt_q    <= sh_cnt_d;
      sh_asr_q    <= sh_asr_d;
    end
  end

  assign resu      = resu_q;
  assign flag_o    = flags_q.o;
  assign flag_c    = flags_q.c;
  assign flag_s    = flags_q.s;
  assign flag_z    = flags_q.z;
  assign illegal   = illegal_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_ula_seq.sv
// Scoreboard bench for ula_seq: directed cases plus randomized ops against an integer reference model.
module tb_ula_seq;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst, in_valid, in_ready, out_valid, out_ready;
  logic [4:0]   op;
  logic [W-1:0] a, b, resu;
  logic         flag_o, flag_c, flag_s, flag_z, illegal;

  always #5 clk = ~clk;

  ula_seq #(.W(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .resu(resu),
    .flag_o(flag_o), .flag_c(flag_c), .flag_s(flag_s), .flag_z(flag_z), .illegal(illegal)
  );

  typedef struct packed {
    logic [W-1:0] r;
    logic o, c, s, z, ill;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_fail = 0;
  logic m_c = 1'b0;
  bit   rand_ready = 1'b0;

  function automatic exp_t model(input logic [4:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                                 input logic cin);
    exp_t e;
    logic [W-1:0] yy;
    longint ux, uy, sx, sy, ci, us, ss;
    int n;
    e = '0;
    if (o[4:3] == 2'b00) begin
      ci = 0;
      case (o[2:0])
        3'd0: yy = y;
        3'd1: begin yy = y;  ci = 1; end
        3'd2: begin yy = y;  ci = longint'(cin); end
        3'd3: begin yy = '0; ci = 1; end
        3'd4: yy = ~y;
        3'd5: begin yy = ~y; ci = 1; end
        3'd6: yy = '1;
        default: begin yy = ~y; ci = longint'(cin); end
      endcase
      ux = longint'(x);
      uy = longint'(yy);
      sx = longint'($signed(x));
      sy = longint'($signed(yy));
      us = ux + uy + ci;
      ss = sx + sy + ci;
      e.r = us[W-1:0];
      e.c = (us >= (64'sd1 <<< W));
      e.o = (ss > ((64'sd1 <<< (W-1)) - 1)) || (ss < -(64'sd1 <<< (W-1)));
`ifdef ULA_SAT_EN
      if (e.o) e.r = (ss > 0) ? {1'b0, {(W-1){1'b1}}} : {1'b1, {(W-1){1'b0}}};
`endif
    end else if (o == 5'b01000 || o == 5'b01001) begin
      n = int'(y % W);
      if (n == 0) e.r = x;
      else if (o == 5'b01000) begin
        e.r = x << n;
        e.c = x[W-n];
      end else begin
        e.r = $signed(x) >>> n;
        e.c = x[n-1];
      end
    end else if (o[4:3] == 2'b01) begin
      e.ill = 1'b1;
    end else begin
      case (o[3:0])
        4'd0:  e.r = '0;
        4'd1:  e.r = x & y;
        4'd2:  e.r = ~x & y;
        4'd3:  e.r = y;
        4'd4:  e.r = x & ~y;
        4'd5:  e.r = x;
        4'd6:  e.r = x ^ y;
        4'd7:  e.r = x | y;
        4'd8:  e.r = ~(x | y);
        4'd9:  e.r = ~(x ^ y);
        4'd10: e.r = ~x;
        4'd11: e.r = ~x | y;
        4'd12: e.r = ~y;
        4'd13: e.r = x | ~y;
        4'd14: e.r = ~(x & y);
        default: e.r = '1;
      endcase
    end
    if (!e.ill) begin
      e.s = e.r[W-1];
      e.z = (e.r == '0);
    end
    return e;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_timeout(input string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: timed out waiting for DUT (t=%0t)", name, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic send(input logic [4:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                      output int waited);
    exp_t e;
    in_valid = 1'b1;
    op = o;
    a = x;
    b = y;
    waited = 0;
    @(negedge clk);
    while (!in_ready && waited < 200) begin
      tick();
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      fail_timeout("accept");
      in_valid = 1'b0;
    end else begin
      e = model(o, x, y, m_c);
      m_c = e.c;
      sb.push_back(e);
      tick();
      in_valid = 1'b0;
    end
  endtask

  task automatic wait_valid(input bit busy_chk, output int lat);
    lat = 1;
    while (!out_valid && lat < 100) begin
      if (busy_chk) check("in_ready_busy", in_ready, 0);
      tick();
      lat++;
    end
    if (!out_valid) fail_timeout("out_valid");
  endtask

  task automatic expect_out(input string name, input logic [W-1:0] r,
                            input logic o, input logic c, input logic s, input logic z,
                            input logic ill);
    check({name, "_resu"}, resu, r);
    check({name, "_flags"}, {flag_o, flag_c, flag_s, flag_z}, {o, c, s, z});
    check({name, "_illegal"}, illegal, ill);
  endtask

  // Scoreboard monitor: a result is consumed on the edge following valid && ready.
  always @(negedge clk) begin
    exp_t got, want;
    if (!rst && out_valid && out_ready) begin
      got = {resu, flag_o, flag_c, flag_s, flag_z, illegal};
      if (sb.size() == 0) begin
        check("unexpected_out", got, '1);
      end else begin
        want = sb.pop_front();
        check("scoreboard", got, want);
      end
    end
  end

  initial begin
    int w, lat, k;
    logic [W-1:0] cap_r;
    logic [4:0]   cap_f;
    logic         stray;

    rst = 1'b1; in_valid = 1'b0; op = '0; a = '0; b = '0; out_ready = 1'b1;
    tick();
    tick();
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 0);
    expect_out("rst", '0, 0, 0, 0, 0, 0);
    rst = 1'b0;

    send(5'b00000, 16'h4800, 16'hE000, w);
    wait_valid(0, lat);
    check("add_latency", lat, 1);
    expect_out("add", 16'h2800, 0, 1, 0, 0, 0);

    send(5'b00000, 16'h4800, 16'h4800, w);
    wait_valid(0, lat);
`ifdef ULA_SAT_EN
    expect_out("add_ovf", 16'h7FFF, 1, 0, 0, 0, 0);
`else
    expect_out("add_ovf", 16'h9000, 1, 0, 1, 0, 0);
`endif

    send(5'b00000, 16'hFFFF, 16'h0001, w);
    wait_valid(0, lat);
    expect_out("add_carry", 16'h0000, 0, 1, 0, 1, 0);
    send(5'b00010, 16'h0000, 16'h0000, w);
    wait_valid(0, lat);
    expect_out("adc", 16'h0001, 0, 0, 0, 0, 0);
    send(5'b00101, 16'h0005, 16'h0003, w);
    wait_valid(0, lat);
    expect_out("sub", 16'h0002, 0, 1, 0, 0, 0);

    send(5'b01001, 16'h8001, 16'd3, w);
    wait_valid(1, lat);
    check("asr_latency", lat, 4);
    expect_out("asr", 16'hF000, 0, 0, 1, 0, 0);

    send(5'b01000, 16'hC000, 16'd1, w);
    wait_valid(1, lat);
    check("lsl_latency", lat, 2);
    expect_out("lsl", 16'h8000, 0, 1, 1, 0, 0);
    tick();

    out_ready = 1'b0;
    send(5'b00000, 16'h1234, 16'h1111, w);
    wait_valid(0, lat);
    cap_r = resu;
    cap_f = {flag_o, flag_c, flag_s, flag_z, illegal};
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bp_resu", resu, cap_r);
      check("bp_flags", {flag_o, flag_c, flag_s, flag_z, illegal}, cap_f);
      check("bp_valid", out_valid, 1);
      check("bp_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    send(5'b10001, 16'hF0F0, 16'h3C3C, w);
    check("bp_same_cycle_accept", w, 0);
    wait_valid(0, lat);

    send(5'b01100, 16'hFFFF, 16'hFFFF, w);
    wait_valid(0, lat);
    expect_out("illegal", 16'h0000, 0, 0, 0, 0, 1);
    send(5'b10110, 16'hA5A5, 16'hA5A5, w);
    wait_valid(0, lat);
    expect_out("illegal_clear", 16'h0000, 0, 0, 0, 1, 0);

    send(5'b01001, 16'h8000, 16'd8, w);
    tick();
    tick();
    tick();
    rst = 1'b1;
    #1;
    check("rst_mid_in_ready", in_ready, 0);
    tick();
    check("rst_mid_out_valid", out_valid, 0);
    expect_out("rst_mid", '0, 0, 0, 0, 0, 0);
    if (sb.size() > 0) void'(sb.pop_back());
    m_c = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    check("rst_release_in_ready", in_ready, 1);
    stray = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      stray |= out_valid;
    end
    check("rst_no_valid", stray, 0);

    rand_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      send(5'($urandom_range(0, 31)), W'($urandom), W'($urandom), w);
      repeat ($urandom_range(0, 2)) tick();
    end

    rand_ready = 1'b0;
    out_ready = 1'b1;
    k = 0;
    while (sb.size() > 0 && k < 200) begin
      tick();
      k++;
    end
    check("drain", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
